// File: rtl/mdu_pkg.sv
// Shared op codes and state encoding for the multiply/divide unit and the decoder that drives it.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'b001;
   localparam logic [2:0] MDU_MULTU = 3'b010;
   localparam logic [2:0] MDU_DIV   = 3'b011;
   localparam logic [2:0] MDU_DIVU  = 3'b100;
   localparam logic [2:0] MDU_MTLO  = 3'b101;
   localparam logic [2:0] MDU_MTHI  = 3'b110;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_t;

   function automatic int mdu_max(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/mdu.sv
// HI/LO multiply/divide unit: result computed at start, committed after MULT_CYCLES/DIV_CYCLES.
// A start while busy, or with an undefined op code, is dropped; busy drives the hazard-unit stall.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = mdu_max(MULT_CYCLES, DIV_CYCLES);
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   mdu_state_t          state;
   logic [CW-1:0]       cnt;
   logic [31:0]         p_hi, p_lo;

   logic signed [63:0]  sa, sb, sbd, prod_s;
   logic [63:0]         prod_u;
   logic [31:0]         quo_s, rem_s, quo_u, rem_u, ubd;
   logic [31:0]         res_hi, res_lo;
   logic [CW-1:0]       lat;
   logic                arith;

   // Divisors forced to 1 when zero so the divider never sees x/0; the result is discarded anyway.
   assign sa     = {{32{a[31]}}, a};
   assign sb     = {{32{b[31]}}, b};
   assign sbd    = (b == 32'd0) ? 64'sd1 : sb;
   assign ubd    = (b == 32'd0) ? 32'd1 : b;
   assign prod_s = sa * sb;
   assign prod_u = {32'd0, a} * {32'd0, b};
   assign quo_s  = 32'(sa / sbd);
   assign rem_s  = 32'(sa % sbd);
   assign quo_u  = a / ubd;
   assign rem_u  = a % ubd;

   // Division by zero re-commits the current hi/lo, so the register looks untouched.
   always_comb begin
      res_hi = hi;
      res_lo = lo;
      lat    = '0;
      arith  = 1'b0;
      case (op)
         MDU_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
            lat    = CW'(MULT_CYCLES);
            arith  = 1'b1;
         end
         MDU_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
            lat    = CW'(MULT_CYCLES);
            arith  = 1'b1;
         end
         MDU_DIV: begin
            if (b != 32'd0) begin
               res_hi = rem_s;
               res_lo = quo_s;
            end
            lat   = CW'(DIV_CYCLES);
            arith = 1'b1;
         end
         MDU_DIVU: begin
            if (b != 32'd0) begin
               res_hi = rem_u;
               res_lo = quo_u;
            end
            lat   = CW'(DIV_CYCLES);
            arith = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         p_hi  <= '0;
         p_lo  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (arith) begin
                     p_hi  <= res_hi;
                     p_lo  <= res_lo;
                     cnt   <= lat;
                     busy  <= 1'b1;
                     state <= RUN;
                  end else if (op == MDU_MTLO) begin
                     lo <= a;
                  end else if (op == MDU_MTHI) begin
                     hi <= a;
                  end
               end
            end
            RUN: begin
               if (cnt == CW'(1)) begin
                  hi    <= p_hi;
                  lo    <= p_lo;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rd_data = rd_sel ? hi : lo;

endmodule
